// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings and defaults for the memory-stage controller.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } memop_e;

    typedef enum logic [1:0] {
        STK_NONE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10
    } stackop_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT2,
        S_RD_WAIT
    } state_e;

    localparam logic [31:0] SP_INIT = 32'h000F_FFFF;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// 16-bit synchronous data-memory bus seen from the memory stage.
interface mem_stage_ctrl_if #(
    parameter int AddrW = 20
);
    logic [AddrW-1:0] mem_addr;
    logic             mem_re;
    logic             mem_we;
    logic [15:0]      mem_wdata;
    logic [15:0]      mem_rdata;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl_sp_reg.sv
// Stack pointer with +/-1 and +/-2 update on completion of a stack op.
module sp_reg
    import mem_stage_ctrl_pkg::*;
#(
    parameter int          AddrW  = 20,
    parameter logic [31:0] SpInit = SP_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             two_i,
    output logic [AddrW-1:0] sp_addr_o,
    output logic [31:0]      sp_next_o
);
    logic [31:0] sp_q, sp_d, step;

    always_comb begin
        step = two_i ? 32'd2 : 32'd1;
        sp_d = sp_q;
        if (en_i && push_i)
            sp_d = sp_q - step;
        else if (en_i && pop_i)
            sp_d = sp_q + step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sp_q <= SpInit;
        else
            sp_q <= sp_d;
    end

    assign sp_addr_o = sp_q[AddrW-1:0];
    assign sp_next_o = sp_d;
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences 16/32-bit loads, stores, pushes
// and pops onto a 16-bit synchronous memory and owns the stack pointer.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int          WbSize = 2,
    parameter int          AddrW  = 20,
    parameter logic [31:0] SpInit = SP_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [1:0]        i_memOp,
    input  logic [1:0]        i_stackOp,
    input  logic              i_is32,
    input  logic [15:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [WbSize-1:0] i_WB,
    input  logic [15:0]       i_alu,
    input  logic [2:0]        i_Rdst,
    input  logic [1:0]        i_changeEPC,
    mem_stage_ctrl_if.master  mem,
    output logic              o_stall,
    output logic              o_done,
    output logic [WbSize-1:0] o_WB,
    output logic [31:0]       o_MemData,
    output logic [15:0]       o_alu,
    output logic [2:0]        o_Rdst,
    output logic [31:0]       o_SP,
    output logic [1:0]        o_changeEPC
);
    state_e state_q, state_d;

    logic             is_push, is_pop, is_rd, is_wr;
    logic [AddrW-1:0] sp_a, a0, a1;
    logic [15:0]      d0, d1;
    logic             done_d, cap_lo;
    logic [31:0]      sp_nxt, rd_word;

    logic              push_q, pop_q, wr_q, is32_q;
    logic [AddrW-1:0]  addr1_q;
    logic [15:0]       wd1_q, lo_q;
    logic [WbSize-1:0] wb_q;
    logic [15:0]       alu_q;
    logic [2:0]        rdst_q;
    logic [1:0]        epc_q;

    logic              cur_push, cur_pop, cur_32;
    logic [WbSize-1:0] cur_wb;
    logic [15:0]       cur_alu;
    logic [2:0]        cur_rdst;
    logic [1:0]        cur_epc;

    logic              done_q;
    logic [WbSize-1:0] owb_q;
    logic [31:0]       omd_q, osp_q;
    logic [15:0]       oalu_q;
    logic [2:0]        ordst_q;
    logic [1:0]        oepc_q;

    // Beat 0 of a push is the high word so the stack reads back low-first.
    always_comb begin
        is_push = (i_stackOp == STK_PUSH);
        is_pop  = (i_stackOp == STK_POP);
        is_rd   = is_pop || (!is_push && i_memOp == MEM_LOAD);
        is_wr   = is_push || (!is_pop && i_memOp == MEM_STORE);
        if (is_push) begin
            a0 = sp_a;
            a1 = sp_a - AddrW'(1);
        end else if (is_pop) begin
            a0 = sp_a + AddrW'(1);
            a1 = sp_a + AddrW'(2);
        end else begin
            a0 = AddrW'(i_addr);
            a1 = AddrW'(i_addr) + AddrW'(1);
        end
        d0 = (is_push && i_is32) ? i_wdata[31:16] : i_wdata[15:0];
        d1 = (is_push && i_is32) ? i_wdata[15:0] : i_wdata[31:16];
    end

    always_comb begin
        state_d       = state_q;
        mem.mem_addr  = '0;
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        o_stall       = 1'b0;
        done_d        = 1'b0;
        cap_lo        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid && is_wr) begin
                    mem.mem_addr  = a0;
                    mem.mem_we    = rst;
                    mem.mem_wdata = d0;
                    o_stall       = i_is32;
                    done_d        = !i_is32;
                    if (i_is32)
                        state_d = S_BEAT2;
                end else if (i_valid && is_rd) begin
                    mem.mem_addr = a0;
                    mem.mem_re   = rst;
                    o_stall      = 1'b1;
                    state_d      = i_is32 ? S_BEAT2 : S_RD_WAIT;
                end else if (i_valid) begin
                    done_d = 1'b1;
                end
            end
            S_BEAT2: begin
                mem.mem_addr = addr1_q;
                if (wr_q) begin
                    mem.mem_we    = rst;
                    mem.mem_wdata = wd1_q;
                    done_d        = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    mem.mem_re = rst;
                    o_stall    = 1'b1;
                    cap_lo     = 1'b1;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle completions happen in IDLE straight from the live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_push = is_push;
            cur_pop  = is_pop;
            cur_32   = i_is32;
            cur_wb   = i_WB;
            cur_alu  = i_alu;
            cur_rdst = i_Rdst;
            cur_epc  = i_changeEPC;
        end else begin
            cur_push = push_q;
            cur_pop  = pop_q;
            cur_32   = is32_q;
            cur_wb   = wb_q;
            cur_alu  = alu_q;
            cur_rdst = rdst_q;
            cur_epc  = epc_q;
        end
        rd_word = is32_q ? {mem.mem_rdata, lo_q}
                         : {16'h0000, mem.mem_rdata};
    end

    sp_reg #(
        .AddrW  (AddrW),
        .SpInit (SpInit)
    ) u_sp (
        .clk       (clk),
        .rst       (rst),
        .en_i      (done_d),
        .push_i    (cur_push),
        .pop_i     (cur_pop),
        .two_i     (cur_32),
        .sp_addr_o (sp_a),
        .sp_next_o (sp_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            wr_q    <= 1'b0;
            is32_q  <= 1'b0;
            addr1_q <= '0;
            wd1_q   <= '0;
            lo_q    <= '0;
            wb_q    <= '0;
            alu_q   <= '0;
            rdst_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_valid) begin
                push_q  <= is_push;
                pop_q   <= is_pop;
                wr_q    <= is_wr;
                is32_q  <= i_is32;
                addr1_q <= a1;
                wd1_q   <= d1;
                wb_q    <= i_WB;
                alu_q   <= i_alu;
                rdst_q  <= i_Rdst;
                epc_q   <= i_changeEPC;
            end
            if (cap_lo)
                lo_q <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q  <= 1'b0;
            owb_q   <= '0;
            omd_q   <= '0;
            oalu_q  <= '0;
            ordst_q <= '0;
            osp_q   <= SpInit;
            oepc_q  <= '0;
        end else begin
            done_q <= done_d;
            owb_q  <= done_d ? cur_wb : '0;
            if (done_d) begin
                omd_q   <= (state_q == S_RD_WAIT) ? rd_word : 32'h0;
                oalu_q  <= cur_alu;
                ordst_q <= cur_rdst;
                osp_q   <= sp_nxt;
                oepc_q  <= cur_epc;
            end
        end
    end

    assign o_done      = done_q;
    assign o_WB        = owb_q;
    assign o_MemData   = omd_q;
    assign o_alu       = oalu_q;
    assign o_Rdst      = ordst_q;
    assign o_SP        = osp_q;
    assign o_changeEPC = oepc_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with an instruction-level memory/SP model.
module tb_mem_stage_ctrl;
    localparam logic [31:0] SPI = 32'h000F_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [1:0]  i_memOp = 2'b00;
    logic [1:0]  i_stackOp = 2'b00;
    logic        i_is32 = 1'b0;
    logic [15:0] i_addr = 16'h0;
    logic [31:0] i_wdata = 32'h0;
    logic [1:0]  i_WB = 2'b00;
    logic [15:0] i_alu = 16'h0;
    logic [2:0]  i_Rdst = 3'b0;
    logic [1:0]  i_changeEPC = 2'b00;
    logic        o_stall, o_done;
    logic [1:0]  o_WB, o_changeEPC;
    logic [31:0] o_MemData, o_SP;
    logic [15:0] o_alu;
    logic [2:0]  o_Rdst;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_stage_ctrl_if #(.AddrW(20)) bus ();

    mem_stage_ctrl #(.WbSize(2), .AddrW(20), .SpInit(SPI)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_memOp(i_memOp),
        .i_stackOp(i_stackOp), .i_is32(i_is32), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_WB(i_WB), .i_alu(i_alu), .i_Rdst(i_Rdst),
        .i_changeEPC(i_changeEPC), .mem(bus), .o_stall(o_stall),
        .o_done(o_done), .o_WB(o_WB), .o_MemData(o_MemData),
        .o_alu(o_alu), .o_Rdst(o_Rdst), .o_SP(o_SP),
        .o_changeEPC(o_changeEPC)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] pmem [0:(1<<20)-1];
    always @(posedge clk) begin
        if (bus.mem_we) pmem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= pmem[bus.mem_addr];
    end

    typedef struct {
        int          due;
        logic [1:0]  wb;
        logic [31:0] md;
        logic [15:0] alu;
        logic [2:0]  rdst;
        logic [31:0] sp;
        logic [1:0]  epc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] gm [logic [19:0]];
    logic [31:0] msp = SPI;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] gm_rd(input logic [19:0] a);
        return gm.exists(a) ? gm[a] : 16'h0000;
    endfunction

    // Instruction-level model: memory image, SP and completion latency.
    task automatic run_op(input logic [1:0] sop, input logic [1:0] mop,
                          input logic is32, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [1:0] wb,
                          input logic [15:0] alu, input logic [2:0] rd,
                          input logic [1:0] epc, output int stalls);
        exp_t        e;
        int          lat;
        bit          push, pop, rdop, wrop;
        logic [19:0] a;
        logic        s;
        push = (sop == 2'b01);
        pop  = (sop == 2'b10);
        rdop = pop || (!push && mop == 2'b01);
        wrop = push || (!pop && mop == 2'b10);
        e.md = 32'h0;
        a = {4'h0, addr};
        if (push) begin
            a = msp[19:0];
            if (is32) begin
                gm[a] = wd[31:16];
                gm[a - 20'd1] = wd[15:0];
                msp = msp - 32'd2;
            end else begin
                gm[a] = wd[15:0];
                msp = msp - 32'd1;
            end
        end else if (pop) begin
            a = msp[19:0] + 20'd1;
            if (is32) begin
                e.md = {gm_rd(a + 20'd1), gm_rd(a)};
                msp = msp + 32'd2;
            end else begin
                e.md = {16'h0, gm_rd(a)};
                msp = msp + 32'd1;
            end
        end else if (rdop) begin
            e.md = is32 ? {gm_rd(a + 20'd1), gm_rd(a)} : {16'h0, gm_rd(a)};
        end else if (wrop) begin
            gm[a] = wd[15:0];
            if (is32) gm[a + 20'd1] = wd[31:16];
        end
        lat = (rdop && is32) ? 3 : ((rdop || (wrop && is32)) ? 2 : 1);
        e.due = cyc + lat;
        e.wb = wb; e.alu = alu; e.rdst = rd; e.sp = msp; e.epc = epc;
        q.push_back(e);
        i_valid = 1'b1; i_stackOp = sop; i_memOp = mop; i_is32 = is32;
        i_addr = addr; i_wdata = wd; i_WB = wb; i_alu = alu;
        i_Rdst = rd; i_changeEPC = epc;
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            #1 s = o_stall;
            @(posedge clk); #1;
            if (!s) break;
            if (k == 0) begin
                i_wdata = ~i_wdata; i_addr = ~i_addr; i_alu = ~i_alu;
                i_Rdst = ~i_Rdst; i_WB = ~i_WB; i_changeEPC = ~i_changeEPC;
                i_is32 = ~i_is32; i_stackOp = 2'b11; i_memOp = 2'b11;
            end
            stalls++;
        end
        i_valid = 1'b0;
        chk("stall_cycles", 32'(stalls), 32'(lat - 1));
    endtask

    initial begin : compare
        exp_t        e;
        logic        x_done;
        logic [1:0]  x_wb, h_epc;
        logic [31:0] h_md, h_sp;
        logic [15:0] h_alu;
        logic [2:0]  h_rdst;
        h_md = 0; h_alu = 0; h_rdst = 0; h_sp = SPI; h_epc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                q.delete();
                h_md = 0; h_alu = 0; h_rdst = 0; h_sp = SPI; h_epc = 0;
            end else begin
                while (q.size() > 0 && q[0].due < cyc) e = q.pop_front();
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    x_done = 1'b1; x_wb = e.wb; h_md = e.md; h_alu = e.alu;
                    h_rdst = e.rdst; h_sp = e.sp; h_epc = e.epc;
                end else begin
                    x_done = 1'b0; x_wb = 2'b00;
                end
                chk("o_done", 32'(o_done), 32'(x_done));
                chk("o_WB", 32'(o_WB), 32'(x_wb));
                chk("o_MemData", o_MemData, h_md);
                chk("o_alu", 32'(o_alu), 32'(h_alu));
                chk("o_Rdst", 32'(o_Rdst), 32'(h_rdst));
                chk("o_SP", o_SP, h_sp);
                chk("o_changeEPC", 32'(o_changeEPC), 32'(h_epc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int st;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_sp", o_SP, SPI);
        chk("rst_md", o_MemData, 32'h0);
        i_valid = 1'b1; i_memOp = 2'b10;
        #1;
        chk("rst_we_gated", 32'(bus.mem_we), 32'h0);
        i_valid = 1'b0; i_memOp = 2'b00;
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // push32 aborted by reset during its second beat
        i_valid = 1'b1; i_stackOp = 2'b01; i_is32 = 1'b1;
        i_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("abort_beat2_we", 32'(bus.mem_we), 32'h1);
        chk("abort_beat2_addr", 32'(bus.mem_addr), 32'h000F_FFFE);
        i_valid = 1'b0; i_stackOp = 2'b00; i_is32 = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("abort_we", 32'(bus.mem_we), 32'h0);
        chk("abort_done", 32'(o_done), 32'h0);
        chk("abort_sp", o_SP, SPI);
        @(negedge clk); #1 rst = 1'b1;
        msp = SPI;
        @(posedge clk); #1;

        run_op(2'b00, 2'b10, 1'b0, 16'h0010, 32'h0000_ABCD,
               2'b01, 16'h0010, 3'd3, 2'b01, st);
        @(posedge clk); #1;
        i_valid = 1'b1; i_memOp = 2'b10; i_addr = 16'h0010;
        i_wdata = 32'h0000_ABCD;
        #1;
        chk("st16_we", 32'(bus.mem_we), 32'h1);
        chk("st16_addr", 32'(bus.mem_addr), 32'h10);
        chk("st16_wdata", 32'(bus.mem_wdata), 32'hABCD);
        chk("st16_stall", 32'(o_stall), 32'h0);
        i_valid = 1'b0; i_memOp = 2'b00;
        #1;

        run_op(2'b01, 2'b00, 1'b1, 16'h0, 32'h1234_5678,
               2'b10, 16'h0001, 3'd1, 2'b00, st);
        chk("push32_hi", 32'(pmem[20'hFFFFF]), 32'h1234);
        chk("push32_lo", 32'(pmem[20'hFFFFE]), 32'h5678);
        chk("push32_sp", o_SP, 32'h000F_FFFD);

        run_op(2'b10, 2'b00, 1'b1, 16'h0, 32'h0,
               2'b11, 16'h0002, 3'd2, 2'b10, st);
        chk("pop32_stall", 32'(st), 32'd2);
        chk("pop32_data", o_MemData, 32'h1234_5678);
        chk("pop32_sp", o_SP, 32'h000F_FFFF);

        run_op(2'b00, 2'b10, 1'b0, 16'h0020, 32'h0000_8001,
               2'b00, 16'h0020, 3'd0, 2'b00, st);
        run_op(2'b00, 2'b01, 1'b0, 16'h0020, 32'h0,
               2'b11, 16'h0020, 3'd5, 2'b10, st);
        chk("ld16_data", o_MemData, 32'h0000_8001);
        chk("ld16_rdst", 32'(o_Rdst), 32'd5);
        chk("ld16_wb", 32'(o_WB), 32'd3);

        repeat (3) @(posedge clk);
        #1;
        chk("bubble_done", 32'(o_done), 32'h0);
        chk("bubble_wb", 32'(o_WB), 32'h0);
        chk("bubble_sp", o_SP, 32'h000F_FFFF);

        run_op(2'b00, 2'b10, 1'b0, 16'h0030, 32'h0000_1111,
               2'b01, 16'h0030, 3'd6, 2'b01, st);
        run_op(2'b00, 2'b10, 1'b0, 16'h0031, 32'h0000_2222,
               2'b10, 16'h0031, 3'd7, 2'b11, st);

        run_op(2'b00, 2'b10, 1'b1, 16'h0040, 32'hDEAD_BEEF,
               2'b01, 16'h0040, 3'd4, 2'b00, st);
        chk("st32_lo", 32'(pmem[20'h00040]), 32'hBEEF);
        run_op(2'b00, 2'b01, 1'b1, 16'h0040, 32'h0,
               2'b10, 16'h0041, 3'd1, 2'b01, st);
        chk("ld32_data", o_MemData, 32'hDEAD_BEEF);

        run_op(2'b00, 2'b10, 1'b0, 16'h0000, 32'h0000_0777,
               2'b00, 16'h0000, 3'd0, 2'b00, st);
        run_op(2'b10, 2'b00, 1'b0, 16'h0, 32'h0,
               2'b11, 16'h0050, 3'd2, 2'b00, st);
        chk("pop16_wrap_data", o_MemData, 32'h0000_0777);
        chk("pop16_wrap_sp", o_SP, 32'h0010_0000);
        run_op(2'b01, 2'b00, 1'b0, 16'h0, 32'h0000_5A5A,
               2'b01, 16'h0060, 3'd3, 2'b10, st);
        run_op(2'b10, 2'b00, 1'b0, 16'h0, 32'h0,
               2'b11, 16'h0070, 3'd4, 2'b01, st);
        chk("pop16_data", o_MemData, 32'h0000_5A5A);

        run_op(2'b00, 2'b00, 1'b0, 16'h0, 32'h0,
               2'b10, 16'hBEEF, 3'd6, 2'b11, st);
        chk("none_alu", 32'(o_alu), 32'h0000_BEEF);

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_completions actual=%0d required=0", q.size());
        end
        checks++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
